// File: rtl/mem_write_buffer.sv
// Write buffer between a CPU and a single-port RAM: stores are queued in a
// circular FIFO (with coalescing), loads are forwarded from it or fetched from RAM.
module mem_write_buffer #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRSIZE-1:0]        cpu_addr,
  input  logic [WIDTH-1:0]           cpu_wdata,
  input  logic                       cpu_we,
  input  logic                       cpu_re,
  output logic [WIDTH-1:0]           cpu_rdata,
  output logic                       cpu_rvalid,
  output logic                       cpu_stall,
  output logic                       ram_req,
  output logic                       ram_we,
  output logic [ADDRSIZE-1:0]        ram_addr,
  output logic [WIDTH-1:0]           ram_wdata,
  input  logic                       ram_ack,
  input  logic [WIDTH-1:0]           ram_rdata,
  output logic [$clog2(DEPTH):0]     buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t                state_q, state_d;
  logic [ADDRSIZE-1:0]   addr_q [DEPTH];
  logic [ADDRSIZE-1:0]   addr_d [DEPTH];
  logic [WIDTH-1:0]      data_q [DEPTH];
  logic [WIDTH-1:0]      data_d [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDRSIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic                  hit, co_hit, store_acc, load_acc, alloc, pop;
  logic [WIDTH-1:0]      hit_data;
  logic [PW-1:0]         idx, co_idx;

  // Walk entries oldest to newest so the last match is the newest data.
  // The head entry is excluded from coalescing while it is on the RAM port.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    co_hit   = 1'b0;
    co_idx   = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q && addr_q[idx] == cpu_addr) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
        if (!(state_q == WR && k == 0)) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
      end
    end
  end

  assign cpu_stall = (count_q == CW'(DEPTH) && cpu_we) || rd_pend_q;
  assign store_acc = cpu_we && !cpu_stall;
  assign load_acc  = cpu_re && !cpu_stall;
  assign alloc     = store_acc && !co_hit;
  assign pop       = (state_q == WR) && ram_ack;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;

    if (store_acc) begin
      if (co_hit) begin
        data_d[co_idx] = cpu_wdata;
      end else begin
        addr_d[tail_q] = cpu_addr;
        data_d[tail_q] = cpu_wdata;
        tail_d         = tail_q + 1'b1;
      end
    end
    if (pop) head_d = head_q + 1'b1;
    count_d = count_q + CW'(alloc) - CW'(pop);

    // A same-cycle store shares cpu_addr, so the load always forwards it.
    if (load_acc) begin
      if (store_acc) begin
        rvalid_d = 1'b1;
        rdata_d  = cpu_wdata;
      end else if (hit) begin
        rvalid_d = 1'b1;
        rdata_d  = hit_data;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = cpu_addr;
      end
    end

    case (state_q)
      IDLE: begin
        if (rd_pend_q)          state_d = RD;
        else if (count_q != '0) state_d = WR;
      end
      WR: if (ram_ack) state_d = IDLE;
      RD: begin
        if (ram_ack) begin
          state_d   = IDLE;
          rd_pend_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Entry storage needs no reset: only entries covered by count_q are looked at.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

  assign ram_req    = (state_q == WR) || (state_q == RD);
  assign ram_we     = (state_q == WR);
  assign ram_addr   = (state_q == WR) ? addr_q[head_q] :
                      (state_q == RD) ? rd_addr_q : '0;
  assign ram_wdata  = (state_q == WR) ? data_q[head_q] : '0;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign buf_count  = count_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: scripted RAM acks, small RAM image for
// final-content checks.
module tb_mem_write_buffer;
  localparam int WIDTH = 32, ADDRSIZE = 12, DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDRSIZE-1:0] cpu_addr;
  logic [WIDTH-1:0]    cpu_wdata;
  logic                cpu_we, cpu_re;
  logic [WIDTH-1:0]    cpu_rdata;
  logic                cpu_rvalid, cpu_stall;
  logic                ram_req, ram_we;
  logic [ADDRSIZE-1:0] ram_addr;
  logic [WIDTH-1:0]    ram_wdata;
  logic                ram_ack;
  logic [WIDTH-1:0]    ram_rdata;
  logic [2:0]          buf_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int rd_cycles = 0;
  logic [WIDTH-1:0] ram_mem [16];

  mem_write_buffer #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .ram_req(ram_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_req && ram_we && ram_ack) ram_mem[ram_addr[3:0]] <= ram_wdata;
    if (ram_req && !ram_we) rd_cycles <= rd_cycles + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (buf_count == 0 && !ram_req) break;
      ram_ack = ram_req;
      step();
    end
    ram_ack = 1'b0;
    tot_cnt++;
    if (buf_count !== 3'd0 || ram_req !== 1'b0)
      $display("FAIL %s_drain: count=%0d req=%b, want 0/0", nm, buf_count, ram_req);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_we = 0; cpu_re = 0; ram_ack = 0; cpu_addr = '0; cpu_wdata = '0; ram_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    tot_cnt++; if (buf_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", buf_count); else pass_cnt++;
    tot_cnt++; if (ram_req !== 1'b0) $display("FAIL rst_req: got %b want 0", ram_req); else pass_cnt++;
    tot_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); else pass_cnt++;
    tot_cnt++; if (cpu_rdata !== '0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else pass_cnt++;
    tot_cnt++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", cpu_stall); else pass_cnt++;
  endtask

  task automatic test_store_drain();
    cpu_we = 1; cpu_addr = 12'd5; cpu_wdata = 32'h11;
    step();
    cpu_we = 0;
    tot_cnt++; if (buf_count !== 3'd1) $display("FAIL st_count1: got %0d want 1", buf_count); else pass_cnt++;
    step();
    tot_cnt++; if ({ram_req, ram_we} !== 2'b11) $display("FAIL st_req_we: got %b want 11", {ram_req, ram_we}); else pass_cnt++;
    tot_cnt++; if (ram_addr !== 12'd5) $display("FAIL st_addr: got %h want 5", ram_addr); else pass_cnt++;
    tot_cnt++; if (ram_wdata !== 32'h11) $display("FAIL st_wdata: got %h want 11", ram_wdata); else pass_cnt++;
    step();
    tot_cnt++; if (ram_req !== 1'b1 || ram_wdata !== 32'h11) $display("FAIL st_hold: req=%b wdata=%h want 1/11", ram_req, ram_wdata); else pass_cnt++;
    ram_ack = 1;
    step();
    ram_ack = 0;
    tot_cnt++; if (buf_count !== 3'd0) $display("FAIL st_count0: got %0d want 0", buf_count); else pass_cnt++;
    tot_cnt++; if (ram_req !== 1'b0) $display("FAIL st_req_off: got %b want 0", ram_req); else pass_cnt++;
    tot_cnt++; if (ram_mem[5] !== 32'h11) $display("FAIL st_mem5: got %h want 11", ram_mem[5]); else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      cpu_we = 1; cpu_addr = 12'(i); cpu_wdata = 32'h100 + 32'(i);
      step();
    end
    cpu_addr = 12'd5; cpu_wdata = 32'h105;
    #1;
    tot_cnt++; if (buf_count !== 3'd4) $display("FAIL full_count4: got %0d want 4", buf_count); else pass_cnt++;
    tot_cnt++; if (cpu_stall !== 1'b1) $display("FAIL full_stall: got %b want 1", cpu_stall); else pass_cnt++;
    step();
    tot_cnt++; if (cpu_stall !== 1'b1 || buf_count !== 3'd4) $display("FAIL full_hold: stall=%b count=%0d want 1/4", cpu_stall, buf_count); else pass_cnt++;
    ram_ack = 1;
    #1;
    tot_cnt++; if (cpu_stall !== 1'b1) $display("FAIL full_pop_stall: got %b want 1", cpu_stall); else pass_cnt++;
    step();
    ram_ack = 0;
    tot_cnt++; if (buf_count !== 3'd3 || cpu_stall !== 1'b0) $display("FAIL full_after_pop: count=%0d stall=%b want 3/0", buf_count, cpu_stall); else pass_cnt++;
    step();
    cpu_we = 0;
    tot_cnt++; if (buf_count !== 3'd4) $display("FAIL full_store5: got %0d want 4", buf_count); else pass_cnt++;
    drain("full");
    tot_cnt++; if (ram_mem[1] !== 32'h101 || ram_mem[5] !== 32'h105) $display("FAIL full_mem: m1=%h m5=%h want 101/105", ram_mem[1], ram_mem[5]); else pass_cnt++;
  endtask

  task automatic test_coalesce();
    cpu_we = 1; cpu_addr = 12'd7; cpu_wdata = 32'hA;
    step();
    cpu_wdata = 32'hB;
    step();
    cpu_we = 0;
    tot_cnt++; if (buf_count !== 3'd1) $display("FAIL coal_count: got %0d want 1", buf_count); else pass_cnt++;
    tot_cnt++; if (ram_req !== 1'b1 || ram_wdata !== 32'hB) $display("FAIL coal_wdata: req=%b wdata=%h want 1/b", ram_req, ram_wdata); else pass_cnt++;
    drain("coal");
    tot_cnt++; if (ram_mem[7] !== 32'hB) $display("FAIL coal_mem: got %h want b", ram_mem[7]); else pass_cnt++;
    cpu_we = 1; cpu_wdata = 32'hA;
    step();
    cpu_we = 0;
    step();
    tot_cnt++; if (ram_req !== 1'b1 || ram_addr !== 12'd7) $display("FAIL infl_wr: req=%b addr=%h want 1/7", ram_req, ram_addr); else pass_cnt++;
    cpu_we = 1; cpu_wdata = 32'hB;
    step();
    cpu_we = 0;
    tot_cnt++; if (buf_count !== 3'd2) $display("FAIL infl_count: got %0d want 2", buf_count); else pass_cnt++;
    tot_cnt++; if (ram_wdata !== 32'hA) $display("FAIL infl_stable: got %h want a", ram_wdata); else pass_cnt++;
    drain("infl");
    tot_cnt++; if (ram_mem[7] !== 32'hB) $display("FAIL infl_mem: got %h want b", ram_mem[7]); else pass_cnt++;
  endtask

  task automatic test_load_hit();
    int rd0;
    rd0 = rd_cycles;
    cpu_we = 1; cpu_addr = 12'd3; cpu_wdata = 32'h22;
    step();
    cpu_we = 0; cpu_re = 1;
    #1;
    tot_cnt++; if (cpu_stall !== 1'b0) $display("FAIL hit_stall: got %b want 0", cpu_stall); else pass_cnt++;
    step();
    cpu_re = 0;
    tot_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h22) $display("FAIL hit_data: rvalid=%b rdata=%h want 1/22", cpu_rvalid, cpu_rdata); else pass_cnt++;
    step();
    tot_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL hit_pulse: got %b want 0", cpu_rvalid); else pass_cnt++;
    drain("hit");
    cpu_we = 1; cpu_re = 1; cpu_addr = 12'h20; cpu_wdata = 32'h55;
    step();
    cpu_we = 0; cpu_re = 0;
    tot_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h55) $display("FAIL fwd_data: rvalid=%b rdata=%h want 1/55", cpu_rvalid, cpu_rdata); else pass_cnt++;
    tot_cnt++; if (buf_count !== 3'd1) $display("FAIL fwd_count: got %0d want 1", buf_count); else pass_cnt++;
    drain("fwd");
    tot_cnt++; if (rd_cycles !== rd0) $display("FAIL hit_no_rd: got %0d RD cycles want 0", rd_cycles - rd0); else pass_cnt++;
  endtask

  task automatic test_load_miss();
    cpu_re = 1; cpu_addr = 12'd9;
    step();
    cpu_re = 0;
    tot_cnt++; if (cpu_stall !== 1'b1 || cpu_rvalid !== 1'b0) $display("FAIL miss_stall: stall=%b rvalid=%b want 1/0", cpu_stall, cpu_rvalid); else pass_cnt++;
    step();
    tot_cnt++; if ({ram_req, ram_we} !== 2'b10 || ram_addr !== 12'd9) $display("FAIL miss_rd: req_we=%b addr=%h want 10/9", {ram_req, ram_we}, ram_addr); else pass_cnt++;
    cpu_we = 1; cpu_addr = 12'h30; cpu_wdata = 32'h33;
    step();
    tot_cnt++; if (cpu_stall !== 1'b1 || buf_count !== 3'd0) $display("FAIL miss_st_ign: stall=%b count=%0d want 1/0", cpu_stall, buf_count); else pass_cnt++;
    cpu_we = 0;
    step();
    ram_ack = 1; ram_rdata = 32'h99;
    step();
    ram_ack = 0; ram_rdata = '0;
    tot_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h99) $display("FAIL miss_data: rvalid=%b rdata=%h want 1/99", cpu_rvalid, cpu_rdata); else pass_cnt++;
    tot_cnt++; if (cpu_stall !== 1'b0 || ram_req !== 1'b0) $display("FAIL miss_done: stall=%b req=%b want 0/0", cpu_stall, ram_req); else pass_cnt++;
  endtask

  task automatic test_miss_after_wr();
    cpu_we = 1; cpu_addr = 12'd1; cpu_wdata = 32'h44;
    step();
    cpu_we = 0; cpu_re = 1; cpu_addr = 12'd2;
    step();
    cpu_re = 0;
    tot_cnt++; if ({ram_req, ram_we} !== 2'b11 || cpu_stall !== 1'b1) $display("FAIL mwr_wr: req_we=%b stall=%b want 11/1", {ram_req, ram_we}, cpu_stall); else pass_cnt++;
    ram_ack = 1;
    step();
    ram_ack = 0;
    tot_cnt++; if (ram_req !== 1'b0 || buf_count !== 3'd0) $display("FAIL mwr_pop: req=%b count=%0d want 0/0", ram_req, buf_count); else pass_cnt++;
    step();
    tot_cnt++; if ({ram_req, ram_we} !== 2'b10 || ram_addr !== 12'd2) $display("FAIL mwr_rd: req_we=%b addr=%h want 10/2", {ram_req, ram_we}, ram_addr); else pass_cnt++;
    ram_ack = 1; ram_rdata = 32'h77;
    step();
    ram_ack = 0; ram_rdata = '0;
    tot_cnt++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h77) $display("FAIL mwr_data: rvalid=%b rdata=%h want 1/77", cpu_rvalid, cpu_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      cpu_we = 1; cpu_addr = 12'(i); cpu_wdata = 32'hC0 + 32'(i);
      step();
    end
    cpu_we = 0;
    tot_cnt++; if (ram_req !== 1'b1 || buf_count !== 3'd3) $display("FAIL rmid_pre: req=%b count=%0d want 1/3", ram_req, buf_count); else pass_cnt++;
    rst = 1;
    step();
    rst = 0;
    tot_cnt++; if (ram_req !== 1'b0 || buf_count !== 3'd0 || cpu_rvalid !== 1'b0) $display("FAIL rmid_post: req=%b count=%0d rvalid=%b want 0/0/0", ram_req, buf_count, cpu_rvalid); else pass_cnt++;
    ram_ack = 1;
    step();
    ram_ack = 0;
    tot_cnt++; if (ram_req !== 1'b0 || buf_count !== 3'd0) $display("FAIL rmid_ack_ign: req=%b count=%0d want 0/0", ram_req, buf_count); else pass_cnt++;
    step();
    tot_cnt++; if (ram_req !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL rmid_idle: req=%b stall=%b want 0/0", ram_req, cpu_stall); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_full();
    test_coalesce();
    test_load_hit();
    test_load_miss();
    test_miss_after_wr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data path width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 12, address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, write-buffer entries (power of two, 2..8).
REQ-004 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port cpu_addr  input  ADDRSIZE  CPU data address.
REQ-007 Port cpu_wdata  input  WIDTH  CPU store data.
REQ-008 Port cpu_we  input  1  CPU store request.
REQ-009 Port cpu_re  input  1  CPU load request.
REQ-010 Port cpu_rdata  output  WIDTH  load data, registered.
REQ-011 Port cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid.
REQ-012 Port cpu_stall  output  1  CPU holds its request while high.
REQ-013 Port ram_req  output  1  RAM transaction request.
REQ-014 Port ram_we  output  1  1 = RAM write, 0 = RAM read.
REQ-015 Port ram_addr  output  ADDRSIZE  RAM address.
REQ-016 Port ram_wdata  output  WIDTH  RAM write data.
REQ-017 Port ram_ack  input  1  RAM completes the current transaction.
REQ-018 Port ram_rdata  input  WIDTH  RAM read data, valid in the ram_ack cycle.
REQ-019 Port buf_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-020 Buffer SHALL be a circular FIFO of {addr, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-021 cpu_stall SHALL be combinational: (buf_count==DEPTH and cpu_we) or read pending (REQ-027).
REQ-022 Store accepted when cpu_we=1 and cpu_stall=0; requests during stall are ignored, not queued.
REQ-023 Accepted store whose address matches a non-in-flight entry SHALL overwrite that entry's data (coalesce), buf_count unchanged; otherwise it allocates at tail.
REQ-024 Entry currently driven on the RAM port (state WR) SHALL NOT be coalesced into; a matching store allocates a new entry.
REQ-025 FSM states IDLE, WR, RD; ram_req=1 exactly in WR and RD; ram_addr/ram_we/ram_wdata stable until ram_ack.
REQ-026 IDLE: read miss pending -> RD; else buf_count>0 -> WR with head entry; else stay. WR or RD with ram_ack=1 -> IDLE; WR completion pops head.
REQ-027 Load with cpu_re=1: hit (address matches any entry, including in-flight) -> cpu_rdata=newest matching data, cpu_rvalid next cycle, no stall; miss -> latch address, stall until response.
REQ-028 Miss SHALL wait for any WR in progress to complete, then RD; cpu_rdata=ram_rdata and cpu_rvalid pulse the cycle after ram_ack; stall drops in that same cycle.
REQ-029 cpu_we and cpu_re in the same cycle: store processed first; load sees the just-written data via forwarding (hit).
REQ-030 Pop and allocate in the same cycle SHALL leave buf_count unchanged; full buffer still stalls stores that cycle (count registered).
REQ-031 ram_ack while ram_req=0 SHALL be ignored.

Reset
REQ-032 rst=1 at a clock edge SHALL set FSM=IDLE, buf_count=0, pointers=0, ram_req=0, cpu_rvalid=0, cpu_rdata=0, pending read cleared.
REQ-033 Reset mid-transaction SHALL drop ram_req after that edge and discard all buffered stores; a later ram_ack is ignored.
REQ-034 cpu_stall SHALL be 0 in the cycle after reset when cpu_we=cpu_re=0.

Verification
REQ-035 Store 0x11 to addr 5, RAM acks after 2 cycles -> ram_req/ram_we=1, ram_addr=5, ram_wdata=0x11; buf_count 1 -> 0 after ack.
REQ-036 RAM ack held low, 5 stores to addrs 1..5 -> first 4 accepted, buf_count=4, cpu_stall=1 on 5th until first ack, then store 5 accepted.
REQ-037 RAM ack held low, stores 0xA then 0xB to addr 7 -> buf_count=1 if addr 7 not in flight, else 2; RAM finally holds 0xB.
REQ-038 Store 0x22 to addr 3 then load addr 3 before drain -> cpu_rvalid next cycle, cpu_rdata=0x22, no RD transaction.
REQ-039 Load addr 9 (miss), RAM returns 0x99 with ack 3 cycles later -> cpu_stall high until cpu_rvalid, cpu_rdata=0x99.
REQ-040 rst pulsed during WR with 3 entries -> next cycle ram_req=0, buf_count=0, cpu_rvalid=0.
